// File: rtl/udp_tx_arb.sv
// ============================================================================
// Module      : udp_tx_arb
// Description : N-channel transmit arbiter in front of the UDP transmit engine
//               (round-robin or fixed priority, length check, gap, timeout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_tx_arb #(
   parameter int          CH_NUM      = 4,
   parameter int          ARB_MODE    = 0,
   parameter logic [15:0] MAX_BYTES   = 16'd1472,
   parameter int          GAP_CYC     = 12,
   parameter logic [19:0] TIMEOUT_CYC = 20'd200000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CH_NUM-1:0]    ch_req,
   input  logic [16*CH_NUM-1:0] ch_byte_num,
   input  logic [48*CH_NUM-1:0] ch_des_mac,
   input  logic [32*CH_NUM-1:0] ch_des_ip,
   input  logic [32*CH_NUM-1:0] ch_data,
   output logic [CH_NUM-1:0]    ch_rd_en,
   output logic [CH_NUM-1:0]    ch_grant,
   output logic [CH_NUM-1:0]    ch_done,
   output logic [CH_NUM-1:0]    ch_err,
   output logic [CH_NUM-1:0]    ch_abort,
   output logic                 tx_start_en,
   output logic [15:0]          tx_byte_num,
   output logic [47:0]          des_mac,
   output logic [31:0]          des_ip,
   output logic [31:0]          tx_data,
   input  logic                 tx_req,
   input  logic                 tx_done,
   output logic                 busy
);

   localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;
   localparam int GAP_W = $clog2(GAP_CYC) + 1;
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 20'd1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARB   = 3'd1,
      S_START = 3'd2,
      S_BUSY  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t              state_q,    state_d;
   logic [CH_NUM-1:0]   req_q,      req_d;
   logic [IDX_W-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [IDX_W-1:0]    idx_q,      idx_d;
   logic [CH_NUM-1:0]   grant_q,    grant_d;
   logic [15:0]         byte_num_q, byte_num_d;
   logic [47:0]         mac_q,      mac_d;
   logic [31:0]         ip_q,       ip_d;
   logic [CH_NUM-1:0]   done_q,     done_d;
   logic [CH_NUM-1:0]   err_q,      err_d;
   logic [CH_NUM-1:0]   abort_q,    abort_d;
   logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;

   logic [15:0] byte_arr [CH_NUM];
   logic [47:0] mac_arr  [CH_NUM];
   logic [31:0] ip_arr   [CH_NUM];
   logic [31:0] data_arr [CH_NUM];

   for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_unpack
      assign byte_arr[gi] = ch_byte_num[16*gi +: 16];
      assign mac_arr[gi]  = ch_des_mac[48*gi +: 48];
      assign ip_arr[gi]   = ch_des_ip[32*gi +: 32];
      assign data_arr[gi] = ch_data[32*gi +: 32];
   end

   function automatic logic [IDX_W-1:0] nxt_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(CH_NUM - 1)) ? '0 : i + IDX_W'(1);
   endfunction

   function automatic logic [CH_NUM-1:0] to_oh(input logic [IDX_W-1:0] i);
      logic [CH_NUM-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Winner search over the requests captured in IDLE.
   logic [IDX_W-1:0] win_idx;
   logic             win_found;
   logic             win_bad;
   int               j;

   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      j         = 0;
      for (int k = 0; k < CH_NUM; k++) begin
         if (ARB_MODE == 0) begin
            j = int'(rr_ptr_q) + k;
            if (j >= CH_NUM) j = j - CH_NUM;
         end else begin
            j = k;
         end
         if (!win_found && req_q[j]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(j);
         end
      end
      win_bad = (byte_arr[win_idx] == 16'd0) || (byte_arr[win_idx] > MAX_BYTES);
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      rr_ptr_d   = rr_ptr_q;
      idx_d      = idx_q;
      grant_d    = grant_q;
      byte_num_d = byte_num_q;
      mac_d      = mac_q;
      ip_d       = ip_q;
      done_d     = '0;
      err_d      = '0;
      abort_d    = '0;
      to_cnt_d   = to_cnt_q;
      gap_cnt_d  = gap_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (|ch_req) begin
               req_d   = ch_req;
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            if (win_bad) begin
               err_d     = to_oh(win_idx);
               rr_ptr_d  = nxt_idx(win_idx);
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end else begin
               idx_d      = win_idx;
               grant_d    = to_oh(win_idx);
               byte_num_d = byte_arr[win_idx];
               mac_d      = mac_arr[win_idx];
               ip_d       = ip_arr[win_idx];
               state_d    = S_START;
            end
         end
         S_START: begin
            to_cnt_d = '0;
            state_d  = S_BUSY;
         end
         S_BUSY: begin
            // tx_done takes precedence over a same-cycle expiry.
            if (tx_done) begin
               done_d    = grant_q;
               rr_ptr_d  = nxt_idx(idx_q);
               grant_d   = '0;
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end else if (to_cnt_q == TO_LAST) begin
               abort_d   = grant_q;
               rr_ptr_d  = nxt_idx(idx_q);
               grant_d   = '0;
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         S_GAP: begin
            grant_d = '0;
            if (gap_cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_q      <= '0;
         rr_ptr_q   <= '0;
         idx_q      <= '0;
         grant_q    <= '0;
         byte_num_q <= '0;
         mac_q      <= '0;
         ip_q       <= '0;
         done_q     <= '0;
         err_q      <= '0;
         abort_q    <= '0;
         to_cnt_q   <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         rr_ptr_q   <= rr_ptr_d;
         idx_q      <= idx_d;
         grant_q    <= grant_d;
         byte_num_q <= byte_num_d;
         mac_q      <= mac_d;
         ip_q       <= ip_d;
         done_q     <= done_d;
         err_q      <= err_d;
         abort_q    <= abort_d;
         to_cnt_q   <= to_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign tx_start_en = (state_q == S_START);
   assign busy        = (state_q != S_IDLE);
   assign tx_data     = (state_q == S_BUSY) ? data_arr[idx_q] : 32'd0;
   assign ch_rd_en    = (state_q == S_BUSY && tx_req) ? grant_q : '0;
   assign ch_grant    = grant_q;
   assign ch_done     = done_q;
   assign ch_err      = err_q;
   assign ch_abort    = abort_q;
   assign tx_byte_num = byte_num_q;
   assign des_mac     = mac_q;
   assign des_ip      = ip_q;

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_arb.sv
// ============================================================================
// Module      : tb_udp_tx_arb
// Description : Self-checking bench for udp_tx_arb (round-robin and priority).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_udp_tx_arb;

   localparam int          CH   = 4;
   localparam int          GAP  = 12;
   localparam int          TO   = 100;
   localparam logic [15:0] MAXB = 16'd1472;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [CH-1:0]     ch_req;
   logic [16*CH-1:0]  ch_byte_num;
   logic [48*CH-1:0]  ch_des_mac;
   logic [32*CH-1:0]  ch_des_ip;
   logic [32*CH-1:0]  ch_data;
   logic              tx_req, tx_done;
   logic              sel_p;

   logic [CH-1:0] r_rd_en, r_grant, r_done, r_err, r_abort;
   logic [CH-1:0] p_rd_en, p_grant, p_done, p_err, p_abort;
   logic          r_start, p_start, r_busy, p_busy;
   logic [15:0]   r_byte, p_byte;
   logic [47:0]   r_mac, p_mac;
   logic [31:0]   r_ip, p_ip, r_data, p_data;

   udp_tx_arb #(.CH_NUM(CH), .ARB_MODE(0), .MAX_BYTES(MAXB), .GAP_CYC(GAP),
                .TIMEOUT_CYC(20'(TO))) dut_rr (
      .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_byte_num(ch_byte_num),
      .ch_des_mac(ch_des_mac), .ch_des_ip(ch_des_ip), .ch_data(ch_data),
      .ch_rd_en(r_rd_en), .ch_grant(r_grant), .ch_done(r_done), .ch_err(r_err),
      .ch_abort(r_abort), .tx_start_en(r_start), .tx_byte_num(r_byte),
      .des_mac(r_mac), .des_ip(r_ip), .tx_data(r_data), .tx_req(tx_req),
      .tx_done(tx_done), .busy(r_busy));

   udp_tx_arb #(.CH_NUM(CH), .ARB_MODE(1), .MAX_BYTES(MAXB), .GAP_CYC(GAP),
                .TIMEOUT_CYC(20'(TO))) dut_pr (
      .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_byte_num(ch_byte_num),
      .ch_des_mac(ch_des_mac), .ch_des_ip(ch_des_ip), .ch_data(ch_data),
      .ch_rd_en(p_rd_en), .ch_grant(p_grant), .ch_done(p_done), .ch_err(p_err),
      .ch_abort(p_abort), .tx_start_en(p_start), .tx_byte_num(p_byte),
      .des_mac(p_mac), .des_ip(p_ip), .tx_data(p_data), .tx_req(tx_req),
      .tx_done(tx_done), .busy(p_busy));

   // Outputs of whichever instance is under test.
   wire [CH-1:0] o_rd_en = sel_p ? p_rd_en : r_rd_en;
   wire [CH-1:0] o_grant = sel_p ? p_grant : r_grant;
   wire [CH-1:0] o_done  = sel_p ? p_done  : r_done;
   wire [CH-1:0] o_err   = sel_p ? p_err   : r_err;
   wire [CH-1:0] o_abort = sel_p ? p_abort : r_abort;
   wire          o_start = sel_p ? p_start : r_start;
   wire          o_busy  = sel_p ? p_busy  : r_busy;
   wire [15:0]   o_byte  = sel_p ? p_byte  : r_byte;
   wire [47:0]   o_mac   = sel_p ? p_mac   : r_mac;
   wire [31:0]   o_ip    = sel_p ? p_ip    : r_ip;
   wire [31:0]   o_data  = sel_p ? p_data  : r_data;

   int checks = 0;
   int errors = 0;
   logic [15:0] len_a [CH];

   typedef struct {
      logic [CH-1:0] mask;
      logic [15:0]   len;
      int            exp_ch;
      bit            exp_err;
      int            done_at;
   } vec_t;
   vec_t vec [11];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [CH-1:0] oh(input int i);
      logic [CH-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input logic [CH-1:0] req, input int ptr);
      for (int k = 0; k < CH; k++)
         if (req[(ptr + k) % CH]) return (ptr + k) % CH;
      return 0;
   endfunction

   function automatic logic [15:0] rand_len();
      if ($urandom_range(0, 5) == 0)
         return ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1473, 65535));
      return 16'($urandom_range(1, 1472));
   endfunction

   task automatic pack_len();
      for (int i = 0; i < CH; i++) ch_byte_num[16*i +: 16] = len_a[i];
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_busy"},  o_busy, 0);
      chk({tag, "_start"}, o_start, 0);
      chk({tag, "_grant"}, o_grant, 0);
      chk({tag, "_rd_en"}, o_rd_en, 0);
      chk({tag, "_pulse"}, {o_done, o_err, o_abort}, 0);
      chk({tag, "_len"},   o_byte, 0);
      chk({tag, "_mac"},   o_mac, 0);
      chk({tag, "_ip"},    o_ip, 0);
      chk({tag, "_data"},  o_data, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ch_req = '0; tx_req = 1'b0; tx_done = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst_n = 1'b1;
   endtask

   // One arbitration from an IDLE cycle through the gap back to IDLE.
   // Called after the negedge of an IDLE cycle with ch_req already set.
   task automatic run_txn(input int w, input bit exp_err, input int done_at);
      logic [CH-1:0] m;
      int            last;
      bit            ok;
      m    = oh(w);
      ok   = (done_at <= TO);
      last = ok ? done_at : TO;
      @(posedge clk); #1;
      tx_req = 1'($urandom); tx_done = 1'($urandom);
      @(negedge clk);
      chk("arb_busy", o_busy, 1);
      chk("arb_start", o_start, 0);
      chk("arb_rd_en", o_rd_en, 0);
      @(posedge clk); #1;
      tx_req = 1'($urandom); tx_done = 1'($urandom);
      @(negedge clk);
      if (exp_err) begin
         chk("err_pulse", o_err, m);
         chk("err_start", o_start, 0);
         chk("err_grant", o_grant, 0);
         chk("err_other", {o_done, o_abort}, 0);
      end else begin
         chk("start_pulse", o_start, 1);
         chk("start_grant", o_grant, m);
         chk("start_len", o_byte, len_a[w]);
         chk("start_mac", o_mac, ch_des_mac[48*w +: 48]);
         chk("start_ip", o_ip, ch_des_ip[32*w +: 32]);
         chk("start_rd_en", o_rd_en, 0);
         chk("start_data", o_data, 0);
         for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            tx_req  = 1'($urandom);
            ch_data = {$urandom, $urandom, $urandom, $urandom};
            tx_done = (k == done_at);
            @(negedge clk);
            chk("busy_rd_en", o_rd_en, tx_req ? m : '0);
            chk("busy_data", o_data, ch_data[32*w +: 32]);
            chk("busy_start", o_start, 0);
            chk("busy_grant", o_grant, m);
            chk("busy_pulse", {o_done, o_err, o_abort}, 0);
         end
         @(posedge clk); #1;
         tx_req = 1'($urandom); tx_done = 1'($urandom);
         @(negedge clk);
         chk("end_done", o_done, ok ? m : '0);
         chk("end_abort", o_abort, ok ? '0 : m);
         chk("end_err", o_err, 0);
         chk("end_grant", o_grant, 0);
         chk("end_rd_en", o_rd_en, 0);
         chk("end_data", o_data, 0);
      end
      for (int g = 1; g < GAP; g++) begin
         @(posedge clk); #1;
         if (g == 1) ch_req[w] = 1'b0;
         tx_req = 1'($urandom); tx_done = 1'($urandom);
         @(negedge clk);
         chk("gap_busy", o_busy, 1);
         chk("gap_start", o_start, 0);
         chk("gap_rd_en", o_rd_en, 0);
         chk("gap_data", o_data, 0);
         chk("gap_pulse", {o_done, o_err, o_abort}, 0);
         if (!exp_err) chk("gap_len_held", o_byte, len_a[w]);
      end
      @(posedge clk); #1;
      tx_req = 1'b0; tx_done = 1'b0;
      @(negedge clk);
      chk("idle_busy", o_busy, 0);
      chk("idle_start", o_start, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int            w, d, model_rr;
      bit            bad;
      logic [CH-1:0] nw;

      rst_n = 1'b0; ch_req = '0; tx_req = 1'b0; tx_done = 1'b0; sel_p = 1'b0;
      ch_data = '0;
      ch_des_mac = {48'h02_00_00_00_00_33, 48'h02_00_00_00_00_22,
                    48'hff_ff_ff_ff_ff_ff, 48'h02_00_00_00_00_00};
      ch_des_ip  = {32'hc0a80167, 32'hc0a80166 ^ 32'h1, 32'hc0a80166, 32'h0a000001};
      for (int i = 0; i < CH; i++) len_a[i] = 16'd64;
      pack_len();

      // Expected winners derived by hand from the round-robin rules.
      vec[0]  = '{4'b1111, 16'd64,   0, 1'b0, 16};
      vec[1]  = '{4'b1111, 16'd64,   1, 1'b0, 18};
      vec[2]  = '{4'b1111, 16'd64,   2, 1'b0, 100};
      vec[3]  = '{4'b1111, 16'd64,   3, 1'b0, 101};
      vec[4]  = '{4'b1111, 16'd64,   0, 1'b0, 16};
      vec[5]  = '{4'b1000, 16'd0,    3, 1'b1, 0};
      vec[6]  = '{4'b1000, 16'd1473, 3, 1'b1, 0};
      vec[7]  = '{4'b1010, 16'd64,   1, 1'b0, 20};
      vec[8]  = '{4'b0011, 16'd64,   0, 1'b0, 16};
      vec[9]  = '{4'b1000, 16'd1472, 3, 1'b0, 30};
      vec[10] = '{4'b0010, 16'd64,   1, 1'b0, 16};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         for (int c = 0; c < CH; c++) len_a[c] = vec[i].len;
         pack_len();
         ch_req = vec[i].mask;
         run_txn(vec[i].exp_ch, vec[i].exp_err, vec[i].done_at);
         ch_req = '0;
      end

      // Reset in the middle of a payload.
      do_reset();
      for (int c = 0; c < CH; c++) len_a[c] = 16'd64;
      pack_len();
      ch_req = 4'b0100;
      run_txn(2, 1'b0, 10);
      ch_req = 4'b1010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_start", o_start, 1);
      chk("mid_grant", o_grant, 4'b1000);
      @(posedge clk); #1;
      tx_req = 1'b1;
      @(negedge clk);
      chk("mid_rd_en", o_rd_en, 4'b1000);
      #2 rst_n = 1'b0;
      #1 chk_reset_outs("async_rst");
      tx_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_no_pulse", {o_done, o_abort}, 0);
      rst_n = 1'b1;
      run_txn(1, 1'b0, 14);
      ch_req = '0;

      // Fixed priority instance.
      sel_p = 1'b1;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         ch_req = 4'b0101;
         run_txn(0, 1'b0, 8 + r);
      end
      ch_req = 4'b0100;
      run_txn(2, 1'b0, 9);
      ch_req = 4'b0110;
      run_txn(1, 1'b0, 5);
      ch_req = '0;
      sel_p = 1'b0;

      // Randomized traffic against the round-robin reference.
      do_reset();
      model_rr = 0;
      for (int r = 0; r < 40; r++) begin
         nw = CH'($urandom) & ~ch_req;
         if ((ch_req | nw) == '0) nw = oh($urandom_range(0, CH - 1));
         for (int c = 0; c < CH; c++) if (nw[c]) len_a[c] = rand_len();
         pack_len();
         ch_req = ch_req | nw;
         w   = rr_pick(ch_req, model_rr);
         bad = (len_a[w] == 16'd0) || (len_a[w] > MAXB);
         case ($urandom_range(0, 7))
            0:       d = TO + 1;
            1:       d = TO;
            default: d = $urandom_range(1, 30);
         endcase
         run_txn(w, bad, d);
         model_rr = (w + 1) % CH;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/udp_tx_arb.md
# udp_tx_arb

Parametrised N-channel transmit arbiter placed in front of the UDP transmit engine. It supersedes the single-source `tx_start_en`/`tx_data` hookup. It collects packet requests from `CH_NUM` independent producers (image, control, status, ...) and grants one at a time, by round-robin or fixed priority. For the granted channel it forwards that channel's length, destination MAC/IP and 32-bit payload words to the engine, and it enforces an inter-packet gap and a completion timeout. It runs entirely in the transmit clock domain.

## Interface
- `CH_NUM`, 4, number of requesting channels (2..8).
- `ARB_MODE`, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest).
- `MAX_BYTES`, 16'd1472, largest legal payload in bytes.
- `GAP_CYC`, 12, idle cycles enforced after each packet (must be ≥1).
- `TIMEOUT_CYC`, 20'd200000, maximum cycles from `tx_start_en` to `tx_done`.

Ports:
- `clk` in 1: transmit clock. One clock only.
- `rst_n` in 1: asynchronous active-low reset.
- `ch_req` in CH_NUM: level request, one bit per channel.
- `ch_byte_num` in 16*CH_NUM: payload bytes, channel i at [16i+15:16i].
- `ch_des_mac` in 48*CH_NUM: destination MAC per channel.
- `ch_des_ip` in 32*CH_NUM: destination IP per channel.
- `ch_data` in 32*CH_NUM: payload word per channel.
- `ch_rd_en` out CH_NUM: word-consumed strobe to the granted channel.
- `ch_grant` out CH_NUM: one-hot, the channel currently owning the engine.
- `ch_done` out CH_NUM: 1-cycle pulse, packet sent.
- `ch_err` out CH_NUM: 1-cycle pulse, request rejected (illegal length).
- `ch_abort` out CH_NUM: 1-cycle pulse, timeout expired.
- `tx_start_en` out 1: start pulse to the engine.
- `tx_byte_num` out 16: latched length.
- `des_mac` out 48: latched destination MAC.
- `des_ip` out 32: latched destination IP.
- `tx_data` out 32: payload word.
- `tx_req` in 1: engine requests the next word.
- `tx_done` in 1: engine finished the packet.
- `busy` out 1: high in every state other than IDLE.

## Operation
- State machine states: IDLE, ARB, START, BUSY, GAP.
- **IDLE:** `ch_req` is sampled only in this state. If any bit is set, go to ARB next cycle.
- **ARB:** select the winner from the requests sampled in IDLE.
  - Round-robin: search from `rr_ptr` upward, wrapping at `CH_NUM-1` back to 0.
  - Priority: select the lowest set index.
- **Length check:** if the winner's `ch_byte_num` is 0 or greater than `MAX_BYTES`:
  - pulse `ch_err[i]`;
  - advance `rr_ptr` to i+1 (mod CH_NUM);
  - go to GAP.
- **Legal length:** latch the index, `tx_byte_num`, `des_mac` and `des_ip`; set `ch_grant` one-hot; go to START.
- **START:** `tx_start_en`=1 for exactly one cycle; clear the timeout counter; go to BUSY.
- **BUSY:**
  - `tx_data` = `ch_data` of the granted index (combinational mux).
  - `ch_rd_en[i]` = `tx_req` & `ch_grant[i]` (combinational).
  - On `tx_done`: pulse `ch_done[i]`, set `rr_ptr`=i+1, go to GAP.
  - When the counter reaches `TIMEOUT_CYC-1` without `tx_done`: pulse `ch_abort[i]`, set `rr_ptr`=i+1, go to GAP.
  - If `tx_done` and the timeout hit in the same cycle, `tx_done` wins and `ch_abort` is not pulsed.
- **GAP:** clear `ch_grant`; count `GAP_CYC` cycles; go to IDLE.
- **Channel contract:**
  - Hold `ch_req`, `ch_byte_num`, `ch_des_mac` and `ch_des_ip` stable until `ch_done`, `ch_err` or `ch_abort` is seen.
  - Drop `ch_req` the cycle after that pulse.
  - A request still high on return to IDLE is treated as a new packet.
- **Outside BUSY:** `tx_data` is 0 and `ch_rd_en` is 0; `tx_req` is ignored.
- `tx_done` outside BUSY is ignored.

## Timing
- **Reset:** all outputs 0, `rr_ptr`=0, state IDLE, counters 0. Reset asserted mid-packet returns to IDLE immediately; the aborted packet gets no `ch_done`/`ch_abort`.
- **Request-to-start latency:** a request visible at IDLE edge t gives ARB at t+1, START (`tx_start_en` high) at t+2.
- `tx_byte_num`, `des_mac` and `des_ip` are valid from the START cycle and held unchanged through GAP.
- **Status pulses:** `ch_done`, `ch_abort` and `ch_err` are registered, high in the first GAP cycle.
- **Gap:** the next `tx_start_en` comes no earlier than `GAP_CYC`+3 cycles after `tx_done`.
- `ch_rd_en` has zero-cycle latency from `tx_req`. Channels present the next word on the cycle after `ch_rd_en`, matching the engine's one-cycle-ahead `tx_req`.
- **Timeout counter:** width ≥ clog2(`TIMEOUT_CYC`); it saturates and does not wrap.

## Test plan
- **Single channel:** ch1 requests with 64 bytes, MAC ff..ff, IP 192.168.1.102.
  - `tx_start_en` 2 cycles after IDLE sample; `tx_byte_num`=64.
  - 16 `ch_rd_en[1]` pulses mirror `tx_req`; `tx_data` equals ch1 words.
  - `ch_done[1]` follows `tx_done`.
- **Round-robin:** ch0..ch3 all request continuously (`ARB_MODE`=0).
  - Grant order 0,1,2,3,0.
  - Consecutive `tx_start_en` spaced ≥ `GAP_CYC`+3 cycles after each `tx_done`.
- **Priority mode:** ch0 and ch2 request continuously (`ARB_MODE`=1).
  - ch0 is granted every time; ch2 is granted only after ch0 drops its request.
- **Illegal length:** ch3 with byte_num 0, then with 1473.
  - `ch_err[3]` pulses each time; no `tx_start_en`; `rr_ptr` advances to 0.
- **Timeout:** `TIMEOUT_CYC`=100; withhold `tx_done`.
  - `ch_abort` at START+100; grant released; next channel served.
  - Separately, assert `tx_done` in the expiry cycle: only `ch_done` pulses.
- **Reset mid-BUSY:** assert `rst_n`=0 during payload.
  - All outputs 0 asynchronously.
  - After release, a pending request restarts from IDLE with `rr_ptr`=0.
